// File: rtl/gmii_udp_rx_pkg.sv
// gmii_udp_rx_pkg
// Shared definitions for the GMII UDP receive path: FSM state encoding,
// Ethernet/IPv4/UDP field constants, CRC-32 polynomial and residue, and the
// header byte offsets (idx values, byte 0 = first byte after the SFD).
// The same field constants are used by the frame generator.
package gmii_udp_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_HDR      = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_TAIL     = 3'd4,
    ST_DROP     = 3'd5
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] UDP_HDR_LEN   = 16'd8;

  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [10:0] IDX_DST_MAC_FIRST = 11'd0;
  localparam logic [10:0] IDX_DST_MAC_LAST  = 11'd5;
  localparam logic [10:0] IDX_ETYPE_HI      = 11'd12;
  localparam logic [10:0] IDX_ETYPE_LO      = 11'd13;
  localparam logic [10:0] IDX_VER_IHL       = 11'd14;
  localparam logic [10:0] IDX_PROTO         = 11'd23;
  localparam logic [10:0] IDX_SRC_IP_FIRST  = 11'd26;
  localparam logic [10:0] IDX_SRC_IP_LAST   = 11'd29;
  localparam logic [10:0] IDX_DST_IP_FIRST  = 11'd30;
  localparam logic [10:0] IDX_DST_IP_LAST   = 11'd33;
  localparam logic [10:0] IDX_SRC_PORT_HI   = 11'd34;
  localparam logic [10:0] IDX_SRC_PORT_LO   = 11'd35;
  localparam logic [10:0] IDX_DST_PORT_HI   = 11'd36;
  localparam logic [10:0] IDX_DST_PORT_LO   = 11'd37;
  localparam logic [10:0] IDX_UDP_LEN_HI    = 11'd38;
  localparam logic [10:0] IDX_UDP_LEN_LO    = 11'd39;
  localparam logic [10:0] IDX_HDR_LAST      = 11'd41;
  localparam logic [10:0] IDX_MAX           = 11'd2047;

  // Shortest legal frame, counted from the first byte after the SFD
  // through the last FCS byte.
  localparam logic [10:0] MIN_FRAME_BYTES  = 11'd64;
  // FCS must follow the payload in full.
  localparam logic [2:0]  POST_PAYLOAD_MIN = 3'd4;

  // Byte sel of a 48-bit MAC in wire order (sel 0 = most significant).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac,
                                          input logic [2:0]  sel);
    case (sel)
      3'd0:    return mac[47:40];
      3'd1:    return mac[39:32];
      3'd2:    return mac[31:24];
      3'd3:    return mac[23:16];
      3'd4:    return mac[15:8];
      default: return mac[7:0];
    endcase
  endfunction

  // Byte sel of a 32-bit IP address in wire order.
  function automatic logic [7:0] ip_byte(input logic [31:0] ip,
                                         input logic [1:0]  sel);
    case (sel)
      2'd0:    return ip[31:24];
      2'd1:    return ip[23:16];
      2'd2:    return ip[15:8];
      default: return ip[7:0];
    endcase
  endfunction

endpackage

// File: rtl/gmii_udp_rx_crc32_d8.sv
// gmii_udp_rx_crc32_d8
// Combinational next-state of a reflected CRC-32 for one byte, LSB first.
// Ports:
//   crc_in  [31:0]  current CRC register
//   data    [7:0]   byte being absorbed
//   crc_out [31:0]  CRC register after the byte
module gmii_udp_rx_crc32_d8
  import gmii_udp_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_udp_rx.sv
// gmii_udp_rx
// GMII receive path: checks preamble/SFD, parses Ethernet II / IPv4 / UDP
// headers, filters on destination MAC/IP/port, streams the UDP payload with
// start/end markers, checks the FCS and reports per-frame status.
// Ports:
//   rx_clk, rst          GMII receive clock, async active-high reset
//   rx_dv, rx_data[7:0]  GMII receive stream
//   pl_valid/pl_data/pl_sop/pl_eop  payload stream, 1 cycle after rx_data
//   udp_len/src_ip/src_port         header fields of the last accepted frame
//   frame_done/frame_good           end-of-frame pulse and status
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | between frames, waiting for the first preamble byte
// ST_PREAMBLE | inside 0x55 preamble, waiting for the SFD
// ST_HDR      | header bytes idx 0..41, filtering and field capture
// ST_PAYLOAD  | forwarding UDP payload bytes
// ST_TAIL     | consuming padding and FCS until rx_dv falls
// ST_DROP     | frame rejected (or reset mid-frame), waiting for rx_dv low
module gmii_udp_rx
  import gmii_udp_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'hA8BBC807D99F,
  parameter logic [31:0] LOCAL_IP   = {8'd192, 8'd168, 8'd0, 8'd1},
  parameter logic [15:0] LOCAL_PORT = 16'h04D2
) (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic        pl_valid,
  output logic [7:0]  pl_data,
  output logic        pl_sop,
  output logic        pl_eop,
  output logic [15:0] udp_len,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic        frame_done,
  output logic        frame_good
);

  state_t      state, state_nxt;
  logic [10:0] idx;
  logic [31:0] crc, crc_nxt;
  logic        mac_u, mac_b, ip_u, ip_b;
  logic        mac_u_nxt, mac_b_nxt, ip_u_nxt, ip_b_nxt;
  logic [7:0]  len_hi;
  logic [15:0] len_nxt;
  logic [31:0] src_ip_sh;
  logic [15:0] src_port_sh;
  logic [15:0] pay_cnt;
  logic        pay_done;
  logic        first_pl;
  logic [2:0]  post_cnt;
  logic        hdr_fail;
  logic        start_frame, accept_hdr, end_frame, pl_fwd;
  logic        frame_byte, tail_byte;
  logic [1:0]  ip_sel;

  gmii_udp_rx_crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (rx_data),
    .crc_out (crc_nxt)
  );

  assign len_nxt    = {len_hi, rx_data};
  assign ip_sel     = idx[1:0] - 2'd2;  // idx 30..33 -> 0..3
  assign frame_byte = rx_dv && (state == ST_HDR || state == ST_PAYLOAD || state == ST_TAIL);
  assign tail_byte  = rx_dv && (state == ST_TAIL);

  // Address filters accumulate a match flag per byte so the decision at the
  // last byte covers the whole field.
  always_comb begin
    mac_u_nxt = ((idx == IDX_DST_MAC_FIRST) ? 1'b1 : mac_u) &&
                (rx_data == mac_byte(LOCAL_MAC, idx[2:0]));
    mac_b_nxt = ((idx == IDX_DST_MAC_FIRST) ? 1'b1 : mac_b) && (rx_data == 8'hFF);
    ip_u_nxt  = ((idx == IDX_DST_IP_FIRST) ? 1'b1 : ip_u) &&
                (rx_data == ip_byte(LOCAL_IP, ip_sel));
    ip_b_nxt  = ((idx == IDX_DST_IP_FIRST) ? 1'b1 : ip_b) && (rx_data == 8'hFF);

    hdr_fail = 1'b0;
    case (idx)
      IDX_DST_MAC_LAST: hdr_fail = !(mac_u_nxt || mac_b_nxt);
      IDX_ETYPE_HI:     hdr_fail = (rx_data != ETH_TYPE_IPV4[15:8]);
      IDX_ETYPE_LO:     hdr_fail = (rx_data != ETH_TYPE_IPV4[7:0]);
      IDX_VER_IHL:      hdr_fail = (rx_data != IPV4_VER_IHL);
      IDX_PROTO:        hdr_fail = (rx_data != IP_PROTO_UDP);
      IDX_DST_IP_LAST:  hdr_fail = !(ip_u_nxt || ip_b_nxt);
      IDX_DST_PORT_HI:  hdr_fail = (rx_data != LOCAL_PORT[15:8]);
      IDX_DST_PORT_LO:  hdr_fail = (rx_data != LOCAL_PORT[7:0]);
      IDX_UDP_LEN_LO:   hdr_fail = (len_nxt < UDP_HDR_LEN);
      default:          hdr_fail = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    accept_hdr  = 1'b0;
    end_frame   = 1'b0;
    pl_fwd      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_dv) state_nxt = (rx_data == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!rx_dv)                        state_nxt = ST_IDLE;
        else if (rx_data == PREAMBLE_BYTE) state_nxt = ST_PREAMBLE;
        else if (rx_data == SFD_BYTE) begin
          state_nxt   = ST_HDR;
          start_frame = 1'b1;
        end
        else                               state_nxt = ST_DROP;
      end
      ST_HDR: begin
        if (!rx_dv)        state_nxt = ST_IDLE;
        else if (hdr_fail) state_nxt = ST_DROP;
        else if (idx == IDX_UDP_LEN_LO) begin
          accept_hdr = 1'b1;
          // Zero-length payload: the UDP checksum bytes are just tail.
          if (len_nxt == UDP_HDR_LEN) state_nxt = ST_TAIL;
        end
        else if (idx == IDX_HDR_LAST) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (!rx_dv) begin
          end_frame = 1'b1;
          state_nxt = ST_IDLE;
        end
        else begin
          pl_fwd = 1'b1;
          if (pay_cnt == 16'd1) state_nxt = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (!rx_dv) begin
          end_frame = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!rx_dv) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_DROP;
    endcase
  end

  // Reset lands in DROP so a frame already on the wire is discarded whole.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) state <= ST_DROP;
    else     state <= state_nxt;
  end

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      crc         <= CRC_INIT;
      mac_u       <= 1'b0;
      mac_b       <= 1'b0;
      ip_u        <= 1'b0;
      ip_b        <= 1'b0;
      len_hi      <= '0;
      src_ip_sh   <= '0;
      src_port_sh <= '0;
      pay_cnt     <= '0;
      pay_done    <= 1'b0;
      first_pl    <= 1'b0;
      post_cnt    <= '0;
      pl_valid    <= 1'b0;
      pl_data     <= '0;
      pl_sop      <= 1'b0;
      pl_eop      <= 1'b0;
      udp_len     <= '0;
      src_ip      <= '0;
      src_port    <= '0;
      frame_done  <= 1'b0;
      frame_good  <= 1'b0;
    end
    else begin
      pl_valid   <= 1'b0;
      pl_sop     <= 1'b0;
      pl_eop     <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;

      if (start_frame) begin
        idx      <= '0;
        crc      <= CRC_INIT;
        pay_done <= 1'b0;
        first_pl <= 1'b1;
        post_cnt <= '0;
      end
      else if (frame_byte) begin
        crc <= crc_nxt;
        if (idx != IDX_MAX) idx <= idx + 11'd1;
      end

      if (state == ST_HDR && rx_dv) begin
        mac_u <= mac_u_nxt;
        mac_b <= mac_b_nxt;
        ip_u  <= ip_u_nxt;
        ip_b  <= ip_b_nxt;
        if (idx >= IDX_SRC_IP_FIRST && idx <= IDX_SRC_IP_LAST)
          src_ip_sh <= {src_ip_sh[23:0], rx_data};
        if (idx == IDX_SRC_PORT_HI || idx == IDX_SRC_PORT_LO)
          src_port_sh <= {src_port_sh[7:0], rx_data};
        if (idx == IDX_UDP_LEN_HI) len_hi <= rx_data;
      end

      // Published fields only change once a header has passed every filter.
      if (accept_hdr) begin
        udp_len  <= len_nxt;
        src_ip   <= src_ip_sh;
        src_port <= src_port_sh;
        pay_cnt  <= len_nxt - UDP_HDR_LEN;
        pay_done <= (len_nxt == UDP_HDR_LEN);
      end

      // pay_cnt counts down the remaining payload; 1 marks the last byte.
      if (pl_fwd) begin
        pl_valid <= 1'b1;
        pl_data  <= rx_data;
        pl_sop   <= first_pl;
        pl_eop   <= (pay_cnt == 16'd1);
        first_pl <= 1'b0;
        pay_cnt  <= pay_cnt - 16'd1;
        if (pay_cnt == 16'd1) pay_done <= 1'b1;
      end

      if (tail_byte && post_cnt != POST_PAYLOAD_MIN) post_cnt <= post_cnt + 3'd1;

      // idx equals the number of bytes received since the SFD.
      if (end_frame) begin
        frame_done <= 1'b1;
        frame_good <= (crc == CRC_RESIDUE) && pay_done &&
                      (post_cnt >= POST_PAYLOAD_MIN) && (idx >= MIN_FRAME_BYTES);
      end
    end
  end

endmodule

// File: tb/tb_gmii_udp_rx.sv
// tb_gmii_udp_rx
// Directed bench for gmii_udp_rx: builds frames byte by byte, appends a
// reference FCS and checks payload stream, header fields and frame status.
module tb_gmii_udp_rx;

  logic        rx_clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_data;
  logic        pl_valid;
  logic [7:0]  pl_data;
  logic        pl_sop;
  logic        pl_eop;
  logic [15:0] udp_len;
  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic        frame_done;
  logic        frame_good;

  always #4 rx_clk = ~rx_clk;

  gmii_udp_rx dut (
    .rx_clk     (rx_clk),
    .rst        (rst),
    .rx_dv      (rx_dv),
    .rx_data    (rx_data),
    .pl_valid   (pl_valid),
    .pl_data    (pl_data),
    .pl_sop     (pl_sop),
    .pl_eop     (pl_eop),
    .udp_len    (udp_len),
    .src_ip     (src_ip),
    .src_port   (src_port),
    .frame_done (frame_done),
    .frame_good (frame_good)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] frame [$];
  logic [7:0] pl_q  [$];

  int         beats    = 0;
  int         sop_cnt  = 0;
  int         eop_cnt  = 0;
  int         done_cnt = 0;
  int         good_cnt = 0;
  int         pos      = 0;
  int         eop_pos  = 0;
  logic [7:0] sop_data = 8'h00;
  logic [7:0] eop_data = 8'h00;

  int         lat_err;
  logic [7:0] prev_byte;
  logic       done_at1;

  int b0, s0, e0, d0, g0, q0;

  always @(negedge rx_clk) begin
    if (pl_valid === 1'b1) begin
      beats <= beats + 1;
      pl_q.push_back(pl_data);
      if (pl_sop === 1'b1) begin
        sop_cnt  <= sop_cnt + 1;
        sop_data <= pl_data;
        pos      <= 1;
      end
      else pos <= pos + 1;
      if (pl_eop === 1'b1) begin
        eop_cnt  <= eop_cnt + 1;
        eop_data <= pl_data;
        eop_pos  <= (pl_sop === 1'b1) ? 1 : pos + 1;
      end
    end
    if (frame_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      if (frame_good === 1'b1) good_cnt <= good_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b0 = beats; s0 = sop_cnt; e0 = eop_cnt; d0 = done_cnt; g0 = good_cnt;
    q0 = pl_q.size();
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int k = 0; k < 8; k++) begin
      if (c[0] ^ d[k]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                       input logic [31:0] dip, input logic [15:0] dport,
                       input logic [15:0] ulen, input bit flip);
    logic [31:0] c;
    logic [15:0] tot;
    frame.delete();
    for (int i = 5; i >= 0; i--) frame.push_back(dmac[8*i +: 8]);
    frame.push_back(8'h02); frame.push_back(8'h00); frame.push_back(8'h00);
    frame.push_back(8'h00); frame.push_back(8'h00); frame.push_back(8'h01);
    frame.push_back(etype[15:8]); frame.push_back(etype[7:0]);
    tot = ulen + 16'd20;
    frame.push_back(8'h45); frame.push_back(8'h00);
    frame.push_back(tot[15:8]); frame.push_back(tot[7:0]);
    frame.push_back(8'h00); frame.push_back(8'h00);
    frame.push_back(8'h40); frame.push_back(8'h00);
    frame.push_back(8'h40); frame.push_back(8'h11);
    frame.push_back(8'h00); frame.push_back(8'h00);
    frame.push_back(8'hC0); frame.push_back(8'hA8);
    frame.push_back(8'h00); frame.push_back(8'h01);
    for (int i = 3; i >= 0; i--) frame.push_back(dip[8*i +: 8]);
    frame.push_back(8'h04); frame.push_back(8'hD2);
    frame.push_back(dport[15:8]); frame.push_back(dport[7:0]);
    frame.push_back(ulen[15:8]); frame.push_back(ulen[7:0]);
    frame.push_back(8'h00); frame.push_back(8'h00);
    for (int i = 0; i < int'(ulen) - 8; i++) frame.push_back(8'(i));
    while (frame.size() < 60) frame.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (frame[i]) c = crc_upd(c, frame[i]);
    c = ~c;
    if (flip) c[0] = ~c[0];
    frame.push_back(c[7:0]);   frame.push_back(c[15:8]);
    frame.push_back(c[23:16]); frame.push_back(c[31:24]);
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge rx_clk);
    if (pl_valid === 1'b1 && pl_data !== prev_byte) lat_err++;
    rx_dv     = 1'b1;
    rx_data   = b;
    prev_byte = b;
  endtask

  // npre preamble bytes, then SFD and the first cut frame bytes (all if
  // cut < 0). rst pulses at frame byte rst_at and releases two bytes later.
  task automatic send(input int npre, input int cut, input int rst_at, input int gap);
    int n;
    n = (cut < 0) ? frame.size() : cut;
    for (int i = 0; i < npre; i++) drive(8'h55);
    drive(8'hD5);
    for (int i = 0; i < n; i++) begin
      drive(frame[i]);
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_pl_valid",   32'(pl_valid),   32'd0);
        chk("rst_udp_len",    32'(udp_len),    32'd0);
        chk("rst_src_ip",     src_ip,          32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
      end
      if (rst_at >= 0 && i == rst_at + 2) begin
        rst = 1'b0;
        snap();
      end
    end
    @(negedge rx_clk);
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    if (gap > 0) begin
      @(negedge rx_clk);
      done_at1 = frame_done;
      repeat (gap - 1) @(negedge rx_clk);
    end
  endtask

  initial begin
    int mm;
    rst = 1'b1; rx_dv = 1'b0; rx_data = 8'h00;
    prev_byte = 8'h00; lat_err = 0; done_at1 = 1'b0;
    repeat (3) @(negedge rx_clk);
    chk("reset_pl_valid",   32'(pl_valid),   32'd0);
    chk("reset_pl_sop",     32'(pl_sop),     32'd0);
    chk("reset_pl_eop",     32'(pl_eop),     32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_frame_good", 32'(frame_good), 32'd0);
    chk("reset_udp_len",    32'(udp_len),    32'd0);
    chk("reset_src_ip",     src_ip,          32'd0);
    chk("reset_src_port",   32'(src_port),   32'd0);
    rst = 1'b0;
    repeat (2) @(negedge rx_clk);

    // broadcast frame, 64-byte payload 0x00..0x3F
    build(48'hFFFFFFFFFFFF, 16'h0800, 32'hFFFFFFFF, 16'h04D2, 16'h0048, 1'b0);
    snap(); lat_err = 0;
    send(7, -1, -1, 4);
    chk("t1_beats",    32'(beats - b0),    32'd64);
    chk("t1_sop_cnt",  32'(sop_cnt - s0),  32'd1);
    chk("t1_sop_data", 32'(sop_data),      32'h00);
    chk("t1_eop_cnt",  32'(eop_cnt - e0),  32'd1);
    chk("t1_eop_data", 32'(eop_data),      32'h3F);
    chk("t1_eop_pos",  32'(eop_pos),       32'd64);
    mm = 0;
    for (int i = 0; i < 64; i++) if (pl_q[q0 + i] !== 8'(i)) mm++;
    chk("t1_payload",  32'(mm),            32'd0);
    chk("t1_latency",  32'(lat_err),       32'd0);
    chk("t1_done_lat", 32'(done_at1),      32'd1);
    chk("t1_done",     32'(done_cnt - d0), 32'd1);
    chk("t1_good",     32'(good_cnt - g0), 32'd1);
    chk("t1_src_ip",   src_ip,             32'hC0A80001);
    chk("t1_src_port", 32'(src_port),      32'h04D2);
    chk("t1_udp_len",  32'(udp_len),       32'h0048);

    // same frame, FCS bit 0 flipped
    build(48'hFFFFFFFFFFFF, 16'h0800, 32'hFFFFFFFF, 16'h04D2, 16'h0048, 1'b1);
    snap();
    send(7, -1, -1, 4);
    chk("t2_beats", 32'(beats - b0),    32'd64);
    chk("t2_eop",   32'(eop_cnt - e0),  32'd1);
    chk("t2_done",  32'(done_cnt - d0), 32'd1);
    chk("t2_good",  32'(good_cnt - g0), 32'd0);

    // wrong destination port
    build(48'hFFFFFFFFFFFF, 16'h0800, 32'hFFFFFFFF, 16'h007B, 16'h0048, 1'b0);
    snap();
    send(7, -1, -1, 4);
    chk("t3_port_beats",   32'(beats - b0),    32'd0);
    chk("t3_port_done",    32'(done_cnt - d0), 32'd0);
    chk("t3_port_udp_len", 32'(udp_len),       32'h0048);

    // ARP EtherType
    build(48'hFFFFFFFFFFFF, 16'h0806, 32'hFFFFFFFF, 16'h04D2, 16'h0048, 1'b0);
    snap();
    send(7, -1, -1, 4);
    chk("t3_etype_beats", 32'(beats - b0),    32'd0);
    chk("t3_etype_done",  32'(done_cnt - d0), 32'd0);

    // unicast MAC off by one bit
    build(48'hA8BBC807D99E, 16'h0800, 32'hC0A80001, 16'h04D2, 16'h0048, 1'b0);
    snap();
    send(7, -1, -1, 4);
    chk("t3_mac_beats", 32'(beats - b0),    32'd0);
    chk("t3_mac_done",  32'(done_cnt - d0), 32'd0);

    // 4-byte payload to local MAC/IP, padded to 64 bytes
    build(48'hA8BBC807D99F, 16'h0800, 32'hC0A80001, 16'h04D2, 16'h000C, 1'b0);
    snap();
    send(7, -1, -1, 4);
    chk("t4_beats",    32'(beats - b0),    32'd4);
    chk("t4_sop_data", 32'(sop_data),      32'h00);
    chk("t4_eop_pos",  32'(eop_pos),       32'd4);
    chk("t4_eop_data", 32'(eop_data),      32'h03);
    chk("t4_done",     32'(done_cnt - d0), 32'd1);
    chk("t4_good",     32'(good_cnt - g0), 32'd1);
    chk("t4_udp_len",  32'(udp_len),       32'h000C);

    // truncated after 10 payload bytes
    build(48'hFFFFFFFFFFFF, 16'h0800, 32'hFFFFFFFF, 16'h04D2, 16'h0048, 1'b0);
    snap();
    send(7, 52, -1, 4);
    chk("t5_beats",    32'(beats - b0),    32'd10);
    chk("t5_eop",      32'(eop_cnt - e0),  32'd0);
    chk("t5_done_lat", 32'(done_at1),      32'd1);
    chk("t5_done",     32'(done_cnt - d0), 32'd1);
    chk("t5_good",     32'(good_cnt - g0), 32'd0);

    // reset at payload byte 5, released with rx_dv still high
    send(7, -1, 46, 4);
    chk("t6_beats_after", 32'(beats - b0),    32'd0);
    chk("t6_done_after",  32'(done_cnt - d0), 32'd0);
    chk("t6_udp_len",     32'(udp_len),       32'd0);
    build(48'hA8BBC807D99F, 16'h0800, 32'hC0A80001, 16'h04D2, 16'h000C, 1'b0);
    snap();
    send(7, -1, -1, 4);
    chk("t6_next_done", 32'(done_cnt - d0), 32'd1);
    chk("t6_next_good", 32'(good_cnt - g0), 32'd1);

    // back-to-back frames, one idle cycle between them
    snap();
    send(7, -1, -1, 0);
    send(7, -1, -1, 4);
    chk("t7_beats", 32'(beats - b0),    32'd8);
    chk("t7_done",  32'(done_cnt - d0), 32'd2);
    chk("t7_good",  32'(good_cnt - g0), 32'd2);

    // SFD with no preamble
    snap();
    send(0, -1, -1, 4);
    chk("t8_beats",    32'(beats - b0),    32'd0);
    chk("t8_done_lat", 32'(done_at1),      32'd0);
    chk("t8_done",     32'(done_cnt - d0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
